// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1RW/1R byte-masked SRAM model.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    // Upper bounds for the mask-expansion helper; callers slice the low bits.
    localparam int MAX_DW = 1024;
    localparam int MAX_MW = 128;

    function automatic int lane_width(input int dw, input int mw);
        return dw / mw;
    endfunction

    function automatic logic [MAX_DW-1:0] expand_wmask(input logic [MAX_MW-1:0] mask,
                                                       input int                lw);
        logic [MAX_DW-1:0] bm;
        logic [MAX_DW-1:0] lane_ones;
        logic [MAX_MW-1:0] m;
        bm        = '0;
        m         = mask;
        lane_ones = ({{(MAX_DW-1){1'b0}}, 1'b1} << lw) - {{(MAX_DW-1){1'b0}}, 1'b1};
        for (int l = 0; l < MAX_MW; l++) begin
            if (m[0]) begin
                bm = bm | (lane_ones << (l * lw));
            end
            m = m >> 1;
        end
        return bm;
    endfunction

endpackage

// File: rtl/sram_1rw1r_wmask_if.sv
// Port bundle for sram_1rw1r_wmask: port 0 read/write, port 1 read-only, status flags.
interface sram_1rw1r_wmask_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 8
);
    logic                   init_done;
    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   dout0_vld;
    logic                   csb1;
    logic [ADDR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0]  dout1;
    logic                   dout1_vld;
    logic                   collision1;

    modport master (
        input  init_done, dout0, dout0_vld, dout1, dout1_vld, collision1,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output init_done, dout0, dout0_vld, dout1, dout1_vld, collision1,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );
endinterface

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then holds READY until reset.
//
// state    | meaning
// ST_CLEAR | writing INIT_VALUE to address cnt_q, one word per cycle
// ST_READY | clear finished, user requests accepted
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_done
);

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        clear_we  = 1'b0;
        init_done = 1'b0;
        case (state_q)
            ST_CLEAR: clear_we  = 1'b1;
            ST_READY: init_done = 1'b1;
            default:  clear_we  = 1'b0;
        endcase
    end

    assign clear_addr = cnt_q;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW + 1R SRAM with lane write mask, read-valid flags and collision flag.
// Define SRAM_BYPASS_EN to forward masked write data to port 1 on a collision.
module sram_1rw1r_wmask
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    WMASK_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    sram_1rw1r_wmask_if.slave      bus
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LANE_W    = lane_width(DATA_WIDTH, WMASK_WIDTH);

    if ((DATA_WIDTH % WMASK_WIDTH) != 0 || DATA_WIDTH >= MAX_DW || WMASK_WIDTH > MAX_MW)
    begin : g_bad_cfg
        $error("sram_1rw1r_wmask: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  init_done;

    sram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .init_done  (init_done)
    );

    logic                   csb0_q, csb0_d, web0_q, csb1_q, csb1_d;
    logic [WMASK_WIDTH-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0]  addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0]  din0_q;

    // Requests presented before init_done are dropped by forcing deselect.
    assign csb0_d = bus.csb0 | ~init_done;
    assign csb1_d = bus.csb1 | ~init_done;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            csb1_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            din0_q   <= '0;
        end else begin
            csb0_q   <= csb0_d;
            web0_q   <= bus.web0;
            csb1_q   <= csb1_d;
            wmask0_q <= bus.wmask0;
            addr0_q  <= bus.addr0;
            addr1_q  <= bus.addr1;
            din0_q   <= bus.din0;
        end
    end

    logic                  rd0, wr0, rd1, coll;
    logic [MAX_DW-1:0]     bm_full;
    logic [DATA_WIDTH-1:0] bitmask;
    logic                  unused_bm_hi;

    assign rd0  = ~csb0_q & web0_q;
    assign wr0  = ~csb0_q & ~web0_q & (|wmask0_q);
    assign rd1  = ~csb1_q;
    assign coll = rd1 & wr0 & (addr1_q == addr0_q);

    assign bm_full      = expand_wmask(MAX_MW'(wmask0_q), LANE_W);
    assign bitmask      = bm_full[DATA_WIDTH-1:0];
    assign unused_bm_hi = ^bm_full[MAX_DW-1:DATA_WIDTH];

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk0) begin
        if (clear_we) begin
            mem[clear_addr] <= INIT_VALUE;
        end else if (wr0) begin
            mem[addr0_q] <= (mem[addr0_q] & ~bitmask) | (din0_q & bitmask);
        end
    end

    logic [DATA_WIDTH-1:0] rd1_word, dout1_d;

    assign rd1_word = mem[addr1_q];

`ifdef SRAM_BYPASS_EN
    assign dout1_d = coll ? ((rd1_word & ~bitmask) | (din0_q & bitmask)) : rd1_word;
`else
    assign dout1_d = rd1_word;
`endif

    logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
    logic                  dout0_vld_q, dout1_vld_q, collision1_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout0_q      <= '0;
            dout1_q      <= '0;
            dout0_vld_q  <= 1'b0;
            dout1_vld_q  <= 1'b0;
            collision1_q <= 1'b0;
        end else begin
            if (rd0) begin
                dout0_q <= mem[addr0_q];
            end
            if (rd1) begin
                dout1_q <= dout1_d;
            end
            dout0_vld_q  <= rd0;
            dout1_vld_q  <= rd1;
            collision1_q <= coll;
        end
    end

    assign bus.init_done  = init_done;
    assign bus.dout0      = dout0_q;
    assign bus.dout0_vld  = dout0_vld_q;
    assign bus.dout1      = dout1_q;
    assign bus.dout1_vld  = dout1_vld_q;
    assign bus.collision1 = collision1_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed self-checking bench for sram_1rw1r_wmask (64x64, 8 byte lanes, INIT_VALUE 0).
module tb_sram_1rw1r_wmask;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    sram_1rw1r_wmask_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .WMASK_WIDTH(8)) bus ();

    sram_1rw1r_wmask #(
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (6),
        .WMASK_WIDTH (8),
        .INIT_VALUE  (64'h0)
    ) dut (
        .clk0   (clk),
        .rst0_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " init_done"},  64'(bus.init_done),  64'd0);
        chk({tag, " dout0"},      bus.dout0,           64'd0);
        chk({tag, " dout0_vld"},  64'(bus.dout0_vld),  64'd0);
        chk({tag, " dout1"},      bus.dout1,           64'd0);
        chk({tag, " dout1_vld"},  64'(bus.dout1_vld),  64'd0);
        chk({tag, " collision1"}, 64'(bus.collision1), 64'd0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.init_done && n < 200);
        chk(tag, 64'(n), 64'd64);
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
        @(negedge clk);
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = a; bus.din0 = d; bus.wmask0 = m;
        @(negedge clk);
        bus.csb0 = 1'b1;
    endtask

    task automatic rd0_chk(input logic [5:0] a, input logic [63:0] exp, input string tag);
        @(negedge clk);
        bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = a;
        @(negedge clk);
        bus.csb0 = 1'b1;
        @(negedge clk);
        chk({tag, " dout0"}, bus.dout0, exp);
        chk({tag, " vld"}, 64'(bus.dout0_vld), 64'd1);
        @(negedge clk);
        chk({tag, " vld one cycle"}, 64'(bus.dout0_vld), 64'd0);
    endtask

    task automatic rd1_chk(input logic [5:0] a, input logic [63:0] exp, input string tag);
        @(negedge clk);
        bus.csb1 = 1'b0; bus.addr1 = a;
        @(negedge clk);
        bus.csb1 = 1'b1;
        @(negedge clk);
        chk({tag, " dout1"}, bus.dout1, exp);
        chk({tag, " vld"}, 64'(bus.dout1_vld), 64'd1);
        chk({tag, " no coll"}, 64'(bus.collision1), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_coll;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.wmask0 = '0; bus.addr0 = '0; bus.din0 = '0;
        bus.csb1 = 1'b1; bus.addr1 = '0;

        #23;
        chk_all_zero("reset");

        // Clear-phase write attempt to 0x3F must be ignored.
        @(negedge clk);
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 6'h3F;
        bus.din0 = 64'hFFFF_FFFF_FFFF_FFFF; bus.wmask0 = 8'hFF;
        rst_n = 1'b1;
        wait_init("init_done latency");
        @(negedge clk);
        bus.csb0 = 1'b1;
        rd0_chk(6'h3F, 64'h0, "clear 0x3F");

        wr(6'd5, 64'h1122_3344_5566_7788, 8'hFF);
        wr(6'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        rd0_chk(6'd5, 64'h1122_3344_AAAA_AAAA, "masked write");

`ifdef SRAM_BYPASS_EN
        exp_coll = 64'h0000_0000_0000_00FF;
`else
        exp_coll = 64'h0;
`endif
        @(negedge clk);
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 6'd9;
        bus.din0 = 64'hFFFF_FFFF_FFFF_FFFF; bus.wmask0 = 8'h01;
        bus.csb1 = 1'b0; bus.addr1 = 6'd9;
        @(negedge clk);
        bus.csb0 = 1'b1; bus.csb1 = 1'b1;
        @(negedge clk);
        chk("coll dout1", bus.dout1, exp_coll);
        chk("coll flag", 64'(bus.collision1), 64'd1);
        chk("coll vld", 64'(bus.dout1_vld), 64'd1);
        @(negedge clk);
        chk("coll flag one cycle", 64'(bus.collision1), 64'd0);
        rd1_chk(6'd9, 64'h0000_0000_0000_00FF, "after coll");

        // Read issued the cycle after a write to the same address sees new data.
        @(negedge clk);
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 6'd7;
        bus.din0 = 64'h0123_4567_89AB_CDEF; bus.wmask0 = 8'hFF;
        @(negedge clk);
        bus.web0 = 1'b1;
        @(negedge clk);
        bus.csb0 = 1'b1;
        chk("b2b port0 write no vld", 64'(bus.dout0_vld), 64'd0);
        @(negedge clk);
        chk("b2b read", bus.dout0, 64'h0123_4567_89AB_CDEF);
        chk("b2b vld", 64'(bus.dout0_vld), 64'd1);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 8'hFF;
            bus.addr0 = i[5:0]; bus.din0 = 64'(i);
        end
        @(negedge clk);
        bus.csb0 = 1'b1;
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("stream dout0", bus.dout0, 64'(c - 2));
                chk("stream dout1", bus.dout1, 64'(65 - c));
                chk("stream vld0", 64'(bus.dout0_vld), 64'd1);
                chk("stream vld1", 64'(bus.dout1_vld), 64'd1);
            end
            if (c < 64) begin
                bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = c[5:0];
                bus.csb1 = 1'b0; bus.addr1 = 6'(63 - c);
            end else begin
                bus.csb0 = 1'b1; bus.csb1 = 1'b1;
            end
        end

        wr(6'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        rd0_chk(6'd3, 64'd3, "wmask zero");

        // Reset in the middle of a clear restarts the full 64-cycle sequence.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_all_zero("reset 2");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-clear reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("restart latency");
        @(negedge clk);
        rd0_chk(6'd40, 64'h0, "recleared 40");
        rd1_chk(6'd5, 64'h0, "recleared 5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_wmask.md
Name: sram_1rw1r_wmask

Overview:
- Parametrised, synthesizable behavioural SRAM model with one read/write port (port 0) and one read-only port (port 1).
- Adds features the plain 1rw0r macro model lacks:
  - a per-byte-lane write mask;
  - read-valid flags;
  - write/read collision detection;
  - a post-reset memory-clear sequencer.
- Used in place of fixed-size OpenRAM macro models for cache/buffer arrays in FreePDK45 designs.

Parameters:
- DATA_WIDTH, 64, bits per word.
- ADDR_WIDTH, 6, address bits; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_WIDTH, 8, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH bits. DATA_WIDTH must be divisible by WMASK_WIDTH; elaboration-time error otherwise.
- INIT_VALUE, 0, word value written to every address by the clear sequencer.

Ports:
- clk0  in  1  clock, all logic on posedge.
- rst0_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once memory clear completes; requests are accepted only while high.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  WMASK_WIDTH  port 0 lane write enables, active high.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_vld  out  1  dout0 holds fresh read data this cycle.
- csb1  in  1  port 1 active-low chip select (read only).
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_vld  out  1  dout1 holds fresh read data this cycle.
- collision1  out  1  port 1 read hit the address being written by port 0 in the same cycle.

Behaviour:
- Reset (async, rst0_n low):
  - FSM enters CLEAR; clear counter = 0.
  - init_done = 0; dout0 = dout1 = 0; dout0_vld = dout1_vld = 0; collision1 = 0.
  - Input registers cleared with csb = 1.
  - Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes INIT_VALUE (full word, mask ignored) to the address given by the counter, then increments the counter.
  - After writing address RAM_DEPTH-1, go to READY. The clear takes exactly RAM_DEPTH cycles after reset release.
  - All port inputs are ignored in CLEAR.
- FSM READY:
  - init_done = 1. Stays in READY until reset.
  - Reset asserted mid-clear or mid-operation returns to CLEAR and restarts at address 0.
- Input sampling: all port inputs are registered on posedge N.
- Port 0 write (csb0 = 0, web0 = 0):
  - Array updated at edge N+1, lanes with wmask0[i] = 1 only; other lanes keep their old data.
  - wmask0 = 0 performs no write.
- Port 0 read (csb0 = 0, web0 = 1):
  - dout0 = mem[addr0] after edge N+1; dout0_vld = 1 for that one cycle.
  - dout0 holds its value until the next port 0 read.
- Port 1 read (csb1 = 0): same timing as a port 0 read, producing dout1 and dout1_vld.
- Port 0 write cycles: dout0_vld = 0 and dout0 holds.
- Deselected ports (csb = 1): vld = 0; data held.
- Collision: a port 1 read and a port 0 write to the same address sampled on the same edge give:
  - collision1 = 1 for one cycle, aligned with dout1_vld;
  - dout1 = old (pre-write) word in all lanes;
  - the write still completes.
- Back-to-back operations: a read of an address written in the previous cycle returns the new data.
- Latency: 1 cycle from sampling edge to valid read data; throughput 1 operation per port per cycle.

Optional Feature:
- SRAM_BYPASS_EN defined: on a collision, dout1 returns the merged word:
  - din0 for masked-on lanes;
  - old data for all other lanes.
  - collision1 still asserts.
- SRAM_BYPASS_EN undefined: the old-data behaviour above applies.

Decomposition:
- Package sram_pkg:
  - FSM state enum (CLEAR, READY);
  - function computing the lane width from DATA_WIDTH and WMASK_WIDTH;
  - function expanding wmask to a bit-level mask.
- Sub-module sram_clear_seq: CLEAR/READY FSM plus address counter; outputs clear_we, clear_addr and init_done.

Test Plan (DATA_WIDTH = 64, ADDR_WIDTH = 6, WMASK_WIDTH = 8, INIT_VALUE = 0):
- Release reset, then hold csb0 = 0, web0 = 0 throughout clear -> init_done rises exactly 64 cycles after release; a read of addr 0x3F returns 0; the clear-phase write has no effect.
- Write addr 5 = 0x1122334455667788 with wmask 0xFF, then write addr 5 = 0xAAAAAAAAAAAAAAAA with wmask 0x0F -> read addr 5 gives 0x11223344AAAAAAAA, dout0_vld high exactly 1 cycle.
- Same cycle: port 0 writes addr 9 = 0xFFFFFFFFFFFFFFFF (wmask 0x01), port 1 reads addr 9 (was 0):
  - with the macro undefined: dout1 = 0, collision1 = 1;
  - with SRAM_BYPASS_EN: dout1 = 0x00000000000000FF, collision1 = 1;
  - a subsequent read gives 0xFF.
- Interleaved reads on both ports every cycle over addresses 0..63 after writing addr i = i -> dout0/dout1 match, 1-cycle latency, no bubbles.
- Assert rst0_n low at clear counter = 20, release -> init_done stays 0 for a full 64 cycles; all outputs 0 during reset.
- Write addr 3 with wmask = 0 -> contents unchanged; read returns prior value.
